// File: rtl/pri_enc_pkg.sv
// ============================================================================
// Module   : pri_enc_pkg
// Brief    : Shared types and helpers for the priority-encoder request queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pri_enc_pkg;

    localparam int unsigned c_max_n = 256;

    typedef logic [c_max_n-1:0] wide_vec_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    // One-hot of idx within an n-bit field; callers size-cast to their width.
    function automatic wide_vec_t onehot(input int unsigned idx, input int unsigned n);
        wide_vec_t r;
        r = '0;
        if (idx < n) begin
            r = wide_vec_t'(1) << idx;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pri_enc_sel.sv
// ============================================================================
// Module   : pri_enc_sel
// Brief    : Combinational selector: highest set index, or round-robin scan
//            downward from ptr_i with wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pri_enc_sel #(
    parameter  int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] v_i,
    input  logic [W-1:0] ptr_i,
    input  logic         rr_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    logic [W-1:0] w_idx_fixed;
    logic [W-1:0] w_idx_rr;
    int           w_pos;

    always_comb begin
        w_idx_fixed = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (|(v_i & (N'(1) << k))) begin
                w_idx_fixed = W'(k);
            end
        end
    end

    // Scan farthest offset first so the nearest hit (ptr itself) is written last.
    always_comb begin
        w_idx_rr = '0;
        w_pos    = 0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            w_pos = int'(ptr_i) - i;
            if (w_pos < 0) begin
                w_pos = w_pos + int'(N);
            end
            if (|(v_i & (N'(1) << w_pos))) begin
                w_idx_rr = W'(w_pos);
            end
        end
    end

    assign idx_o = rr_i ? w_idx_rr : w_idx_fixed;
    assign any_o = |v_i;

endmodule

`default_nettype wire

// File: rtl/pri_enc_queue.sv
// ============================================================================
// Module   : pri_enc_queue
// Brief    : Request-capturing priority encoder offering one pending index at
//            a time on a valid/ready port (fixed priority or round-robin).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pri_enc_queue
    import pri_enc_pkg::*;
#(
    parameter  int unsigned N  = 8,
    parameter  bit          RR = 1'b0,
    localparam int unsigned W  = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         busy
);

    state_e       state_q, state_d;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [N-1:0] pending_q, pending_d;

    logic         w_acc;
    logic [N-1:0] w_oh;
    logic [N-1:0] w_rem;
    logic [W-1:0] w_ptr_acc;
    logic [W-1:0] w_sel_idle_idx, w_sel_b2b_idx;
    logic         w_sel_idle_any, w_sel_b2b_any;

    assign w_acc     = (state_q == OFFER) && out_ready;
    assign w_oh      = N'(onehot(32'(out_idx_q), N));
    assign pending_d = (pending_q & ~(w_acc ? w_oh : '0)) | req;
    // A set-wins re-request of the accepted index is withheld until the next selection.
    assign w_rem     = pending_d & ~w_oh;
    assign w_ptr_acc = (out_idx_q == '0) ? W'(N - 1) : out_idx_q - 1'b1;

    pri_enc_sel #(.N(N)) u_sel_idle (
        .v_i   (pending_d),
        .ptr_i (ptr_q),
        .rr_i  (RR),
        .idx_o (w_sel_idle_idx),
        .any_o (w_sel_idle_any)
    );

    pri_enc_sel #(.N(N)) u_sel_b2b (
        .v_i   (w_rem),
        .ptr_i (w_ptr_acc),
        .rr_i  (RR),
        .idx_o (w_sel_b2b_idx),
        .any_o (w_sel_b2b_any)
    );

    always_comb begin
        state_d   = state_q;
        out_idx_d = out_idx_q;
        ptr_d     = ptr_q;
        case (state_q)
            IDLE: begin
                if (w_sel_idle_any) begin
                    out_idx_d = w_sel_idle_idx;
                    state_d   = OFFER;
                end
            end
            OFFER: begin
                if (w_acc) begin
                    ptr_d = w_ptr_acc;
                    if (w_sel_b2b_any) begin
                        out_idx_d = w_sel_b2b_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out_idx_q <= '0;
            ptr_q     <= W'(N - 1);
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            out_idx_q <= out_idx_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
        end
    end

    assign out_valid = (state_q == OFFER);
    assign out_idx   = out_idx_q;
    assign pending   = pending_q;
    assign busy      = |pending_q;

endmodule

`default_nettype wire

// File: tb/tb_pri_enc_queue.sv
// ============================================================================
// Module   : tb_pri_enc_queue
// Brief    : Directed vector bench for pri_enc_queue, fixed and round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pri_enc_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_fp, req_rr;
    logic       rdy_fp, rdy_rr;
    logic       v_fp, v_rr;
    logic [2:0] idx_fp, idx_rr;
    logic [7:0] pend_fp, pend_rr;
    logic       busy_fp, busy_rr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pri_enc_queue #(.N(8), .RR(1'b0)) u_fp (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_fp),
        .out_valid (v_fp),
        .out_idx   (idx_fp),
        .out_ready (rdy_fp),
        .pending   (pend_fp),
        .busy      (busy_fp)
    );

    pri_enc_queue #(.N(8), .RR(1'b1)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_rr),
        .out_valid (v_rr),
        .out_idx   (idx_rr),
        .out_ready (rdy_rr),
        .pending   (pend_rr),
        .busy      (busy_rr)
    );

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic       exp_v;
        logic [2:0] exp_idx;
        logic [7:0] exp_pend;
    } vec_t;

    vec_t tbl[32];
    int   n_tbl = 0;

    task automatic add(input logic [7:0] rq, input logic rd, input logic ev,
                       input logic [2:0] ei, input logic [7:0] ep);
        tbl[n_tbl].req      = rq;
        tbl[n_tbl].rdy      = rd;
        tbl[n_tbl].exp_v    = ev;
        tbl[n_tbl].exp_idx  = ei;
        tbl[n_tbl].exp_pend = ep;
        n_tbl++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;

        rst_n  = 1'b0;
        req_fp = '0; rdy_fp = 1'b0;
        req_rr = '0; rdy_rr = 1'b0;

        // idle
        for (int i = 0; i < 5; i++) add(8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        // 0x81 pulse drains 7 then 0
        add(8'h81, 1'b1, 1'b1, 3'd7, 8'h81);
        add(8'h00, 1'b1, 1'b1, 3'd0, 8'h01);
        add(8'h00, 1'b1, 1'b0, 3'd0, 8'h00);
        // frozen offer while not ready
        add(8'h04, 1'b0, 1'b1, 3'd2, 8'h04);
        add(8'h40, 1'b0, 1'b1, 3'd2, 8'h44);
        add(8'h00, 1'b0, 1'b1, 3'd2, 8'h44);
        add(8'h00, 1'b1, 1'b1, 3'd6, 8'h40);
        add(8'h00, 1'b1, 1'b0, 3'd0, 8'h00);
        // set wins on accepted index 3
        add(8'h08, 1'b0, 1'b1, 3'd3, 8'h08);
        add(8'h08, 1'b1, 1'b0, 3'd0, 8'h08);
        add(8'h00, 1'b1, 1'b1, 3'd3, 8'h08);
        add(8'h00, 1'b1, 1'b0, 3'd0, 8'h00);
        add(8'h00, 1'b1, 1'b0, 3'd0, 8'h00);
        // two bits, back-to-back
        add(8'h0A, 1'b0, 1'b1, 3'd3, 8'h0A);
        add(8'h00, 1'b1, 1'b1, 3'd1, 8'h02);
        add(8'h00, 1'b1, 1'b0, 3'd0, 8'h00);

        #12;
        chk("rst_valid", 32'(v_fp), 32'd0);
        chk("rst_idx",   32'(idx_fp), 32'd0);
        chk("rst_pend",  32'(pend_fp), 32'd0);
        chk("rst_busy",  32'(busy_fp), 32'd0);
        chk("rst_rr_valid", 32'(v_rr), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < n_tbl; i++) begin
            req_fp = tbl[i].req;
            rdy_fp = tbl[i].rdy;
            step();
            chk($sformatf("v%0d_valid", i), 32'(v_fp), 32'(tbl[i].exp_v));
            chk($sformatf("v%0d_pend", i),  32'(pend_fp), 32'(tbl[i].exp_pend));
            chk($sformatf("v%0d_busy", i),  32'(busy_fp), 32'(|tbl[i].exp_pend));
            if (tbl[i].exp_v) chk($sformatf("v%0d_idx", i), 32'(idx_fp), 32'(tbl[i].exp_idx));
        end

        // asynchronous reset while offering
        req_fp = 8'h20; rdy_fp = 1'b0;
        step();
        chk("pre_rst_valid", 32'(v_fp), 32'd1);
        chk("pre_rst_idx",   32'(idx_fp), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(v_fp), 32'd0);
        chk("async_rst_pend",  32'(pend_fp), 32'd0);
        chk("async_rst_busy",  32'(busy_fp), 32'd0);
        req_fp = 8'h00;
        @(negedge clk);
        rst_n  = 1'b1;
        req_fp = 8'h10;
        step();
        chk("post_rst_valid", 32'(v_fp), 32'd1);
        chk("post_rst_idx",   32'(idx_fp), 32'd4);
        chk("post_rst_pend",  32'(pend_fp), 32'h10);
        req_fp = 8'h00; rdy_fp = 1'b1;
        step();
        chk("post_rst_drain", 32'(v_fp), 32'd0);

        // round-robin fairness with all requests held
        rdy_rr = 1'b1;
        for (int i = 0; i < 9; i++) begin
            req_rr = 8'hFF;
            step();
            chk($sformatf("rr%0d_valid", i), 32'(v_rr), 32'd1);
            chk($sformatf("rr%0d_idx", i), 32'(idx_rr), 32'((15 - i) % 8));
        end
        req_rr = 8'h00;
        cnt = 0;
        for (int i = 0; i < 20 && busy_rr; i++) begin
            if (v_rr) cnt++;
            step();
        end
        chk("rr_drain_busy",    32'(busy_rr), 32'd0);
        chk("rr_drain_accepts", 32'(cnt), 32'd8);
        chk("rr_drain_valid",   32'(v_rr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
